// File: rtl/ex_stage_div_if.sv
// ============================================================================
//  Module      : ex_stage_div_if
//  Description : ID->EX->MEM handshake, bundles and data SRAM request port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_stage_div_if;
    logic           ID_to_EX_valid;
    logic [150:0]   ID_EX_reg;
    logic           MEM_allow_in;
    logic           EX_allow_in;
    logic           EX_to_MEM_valid;
    logic [70:0]    EX_MEM_reg;
    logic           data_sram_en;
    logic [3:0]     data_sram_we;
    logic [31:0]    data_sram_addr;
    logic [31:0]    data_sram_wdata;

    // master: the surrounding pipeline (ID producer, MEM consumer)
    modport master (
        output ID_to_EX_valid, ID_EX_reg, MEM_allow_in,
        input  EX_allow_in, EX_to_MEM_valid, EX_MEM_reg,
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  ID_to_EX_valid, ID_EX_reg, MEM_allow_in,
        output EX_allow_in, EX_to_MEM_valid, EX_MEM_reg,
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
endinterface

`default_nettype wire

// File: rtl/ex_stage_div.sv
// ============================================================================
//  Module      : ex_stage_div
//  Description : EX stage with one-hot ALU, SRAM request and 32-cycle divider
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage_div (
    input  logic            clk,
    input  logic            reset,
    ex_stage_div_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    logic           r_ex_valid;
    logic [31:0]    r_pc;
    logic [11:0]    r_alu_op;
    logic [31:0]    r_src1;
    logic [31:0]    r_src2;
    logic [2:0]     r_div_op;
    logic           r_mem_we;
    logic [31:0]    r_rkd;
    logic           r_gr_we;
    logic [4:0]     r_dest;
    logic           r_res_from_mem;

    div_state_t     r_state;
    div_state_t     w_state_nxt;
    logic [4:0]     r_count;
    logic [31:0]    r_rem;
    logic [31:0]    r_quo;
    logic [31:0]    r_dvs;
    logic           r_neg_q;
    logic           r_neg_r;

    logic           w_ready_go;
    logic           w_allow_in;
    logic           w_sram_en;
    logic           w_div_start;
    logic           w_s1_neg;
    logic           w_s2_neg;
    logic [31:0]    w_abs1;
    logic [31:0]    w_abs2;
    logic [32:0]    w_shift;
    logic [32:0]    w_diff;
    logic           w_sub_ok;
    logic [31:0]    w_quo_final;
    logic [31:0]    w_rem_final;
    logic [31:0]    w_div_res;
    logic [4:0]     w_sh;
    logic [31:0]    w_sra;
    logic [31:0]    w_alu_res;
    logic [31:0]    w_result;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_ready_go = !r_div_op[0] || (r_state == S_DONE);
    assign w_allow_in = !r_ex_valid || (w_ready_go && bus.MEM_allow_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
        end else if (w_allow_in) begin
            r_ex_valid <= bus.ID_to_EX_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_allow_in && bus.ID_to_EX_valid) begin
            r_pc           <= bus.ID_EX_reg[150:119];
            r_alu_op       <= bus.ID_EX_reg[118:107];
            r_src1         <= bus.ID_EX_reg[106:75];
            r_src2         <= bus.ID_EX_reg[74:43];
            r_div_op       <= bus.ID_EX_reg[42:40];
            r_mem_we       <= bus.ID_EX_reg[39];
            r_rkd          <= bus.ID_EX_reg[38:7];
            r_gr_we        <= bus.ID_EX_reg[6];
            r_dest         <= bus.ID_EX_reg[5:1];
            r_res_from_mem <= bus.ID_EX_reg[0];
        end
    end

    // ------------------------------------------------------------------
    // ALU: AND-OR of one-hot selected operations
    // ------------------------------------------------------------------
    assign w_sh  = r_src2[4:0];
    assign w_sra = $unsigned($signed(r_src1) >>> w_sh);

    always_comb begin
        w_alu_res = '0;
        if (r_alu_op[0])  w_alu_res = w_alu_res | (r_src1 + r_src2);
        if (r_alu_op[1])  w_alu_res = w_alu_res | (r_src1 - r_src2);
        if (r_alu_op[2])  w_alu_res = w_alu_res | {31'd0, $signed(r_src1) < $signed(r_src2)};
        if (r_alu_op[3])  w_alu_res = w_alu_res | {31'd0, r_src1 < r_src2};
        if (r_alu_op[4])  w_alu_res = w_alu_res | (r_src1 & r_src2);
        if (r_alu_op[5])  w_alu_res = w_alu_res | ~(r_src1 | r_src2);
        if (r_alu_op[6])  w_alu_res = w_alu_res | (r_src1 | r_src2);
        if (r_alu_op[7])  w_alu_res = w_alu_res | (r_src1 ^ r_src2);
        if (r_alu_op[8])  w_alu_res = w_alu_res | (r_src1 << w_sh);
        if (r_alu_op[9])  w_alu_res = w_alu_res | (r_src1 >> w_sh);
        if (r_alu_op[10]) w_alu_res = w_alu_res | w_sra;
        if (r_alu_op[11]) w_alu_res = w_alu_res | r_src2;
    end

    // ------------------------------------------------------------------
    // Divider control
    // ------------------------------------------------------------------
    assign w_div_start = (r_state == S_IDLE) && r_ex_valid && r_div_op[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_ex_valid && r_div_op[0]) w_state_nxt = S_BUSY;
            S_BUSY: if (r_count == 5'd31)          w_state_nxt = S_DONE;
            S_DONE: if (bus.MEM_allow_in)          w_state_nxt = S_IDLE;
            default:                               w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Divider datapath: restoring division on magnitudes
    // ------------------------------------------------------------------
    assign w_s1_neg = r_div_op[1] && r_src1[31];
    assign w_s2_neg = r_div_op[1] && r_src2[31];
    assign w_abs1   = w_s1_neg ? (32'd0 - r_src1) : r_src1;
    assign w_abs2   = w_s2_neg ? (32'd0 - r_src2) : r_src2;

    assign w_shift  = {r_rem, r_quo[31]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_sub_ok = !w_diff[32];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_div_start) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= w_abs1;
            r_dvs   <= w_abs2;
            r_neg_q <= w_s1_neg ^ w_s2_neg;
            r_neg_r <= w_s1_neg;
        end else if (r_state == S_BUSY) begin
            r_count <= r_count + 5'd1;
            // A kept remainder is below the divisor, so bit 32 is always zero
            r_rem   <= w_sub_ok ? w_diff[31:0] : w_shift[31:0];
            r_quo   <= {r_quo[30:0], w_sub_ok};
        end
    end

    // Divide-by-zero bypasses the sign fix-up entirely
    assign w_quo_final = (r_src2 == 32'd0) ? 32'hFFFF_FFFF
                       : (r_neg_q ? (32'd0 - r_quo) : r_quo);
    assign w_rem_final = (r_src2 == 32'd0) ? r_src1
                       : (r_neg_r ? (32'd0 - r_rem) : r_rem);
    assign w_div_res   = r_div_op[2] ? w_rem_final : w_quo_final;
    assign w_result    = r_div_op[0] ? w_div_res : w_alu_res;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_sram_en = r_ex_valid && (r_mem_we || r_res_from_mem) && bus.MEM_allow_in;

    assign bus.EX_allow_in     = w_allow_in;
    assign bus.EX_to_MEM_valid = r_ex_valid && w_ready_go;
    assign bus.EX_MEM_reg      = {r_pc, r_gr_we, r_dest, w_result, r_res_from_mem};
    assign bus.data_sram_en    = w_sram_en;
    assign bus.data_sram_we    = {4{w_sram_en && r_mem_we}};
    assign bus.data_sram_addr  = w_alu_res;
    assign bus.data_sram_wdata = r_rkd;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_div.sv
// ============================================================================
//  Module      : tb_ex_stage_div
//  Description : Vector table, directed sequences and random checks for EX
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage_div;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    ex_stage_div_if bus ();

    ex_stage_div dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [2:0]  dv;
        logic [31:0] exp;
        int          lat;
        int          lows;
    } vec_t;

    vec_t         vecs [18];
    logic [150:0] ins;
    logic [150:0] ins_a;
    logic [150:0] ins_b;
    logic [31:0]  s1;
    logic [31:0]  s2;
    logic [2:0]   dv;
    int           kind;
    int           op;
    int           lat;

    function automatic logic [150:0] mk(input logic [31:0] pc, input int opi,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] d, input logic mem_we,
                                        input logic [31:0] rkd, input logic gr_we,
                                        input logic [4:0] dest, input logic rfm);
        logic [11:0] oh;
        oh = '0;
        if (opi >= 0) oh[opi] = 1'b1;
        return {pc, oh, a, b, d, mem_we, rkd, gr_we, dest, rfm};
    endfunction

    // Reference: plain arithmetic on the decoded fields
    function automatic logic [31:0] model(input logic [150:0] x);
        logic [11:0] oh;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  d;
        logic [31:0] res;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        oh = x[118:107];
        a  = x[106:75];
        b  = x[74:43];
        d  = x[42:40];
        res = '0;
        if (d[0]) begin
            if (b == 32'd0) return d[2] ? a : 32'hFFFF_FFFF;
            if (d[1]) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            q = sa / sb;
            r = sa % sb;
            return d[2] ? r[31:0] : q[31:0];
        end
        for (int i = 0; i < 12; i++) begin
            if (oh[i]) begin
                case (i)
                    0:  res = a + b;
                    1:  res = a - b;
                    2:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3:  res = (a < b) ? 32'd1 : 32'd0;
                    4:  res = a & b;
                    5:  res = ~(a | b);
                    6:  res = a | b;
                    7:  res = a ^ b;
                    8:  res = a << b[4:0];
                    9:  res = a >> b[4:0];
                    10: res = $signed(a) >>> b[4:0];
                    default: res = b;
                endcase
            end
        end
        return res;
    endfunction

    task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic recover();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.ID_to_EX_valid = 1'b0;
        bus.MEM_allow_in   = 1'b1;
    endtask

    // Issue one instruction into an empty stage, optionally stall MEM, then drain it
    task automatic exec(input string nm, input logic [150:0] x, input int stall,
                        input logic [31:0] exp_res, input int exp_lat, input int exp_lows);
        int          l;
        int          lows;
        logic        exp_en;
        logic [70:0] exp_bundle;
        exp_en     = x[39] | x[0];
        exp_bundle = {x[150:119], x[6], x[5:1], exp_res, x[0]};
        bus.ID_to_EX_valid = 1'b1;
        bus.ID_EX_reg      = x;
        bus.MEM_allow_in   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ID_to_EX_valid = 1'b0;
        l = 1;
        lows = 0;
        while (!bus.EX_to_MEM_valid && l < 100) begin
            if (!bus.EX_allow_in) lows++;
            l++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 71'(l), 71'(exp_lat));
        if (!bus.EX_to_MEM_valid) begin
            recover();
            return;
        end
        chk({nm, " allow_in low cycles"}, 71'(lows), 71'(exp_lows));
        chk({nm, " bundle"}, bus.EX_MEM_reg, exp_bundle);
        if (stall > 0) begin
            bus.MEM_allow_in = 1'b0;
            for (int s = 0; s < stall; s++) begin
                #1;
                chk({nm, " stall valid"},    71'(bus.EX_to_MEM_valid), 71'(1));
                chk({nm, " stall bundle"},   bus.EX_MEM_reg, exp_bundle);
                chk({nm, " stall sram_en"},  71'(bus.data_sram_en), 71'(0));
                chk({nm, " stall allow_in"}, 71'(bus.EX_allow_in), 71'(0));
                @(negedge clk);
            end
        end
        bus.MEM_allow_in = 1'b1;
        #1;
        chk({nm, " allow_in at leave"}, 71'(bus.EX_allow_in), 71'(1));
        chk({nm, " sram_en"}, 71'(bus.data_sram_en), 71'(exp_en));
        chk({nm, " sram_we"}, 71'(bus.data_sram_we), 71'({4{exp_en & x[39]}}));
        if (exp_en) begin
            chk({nm, " sram_wdata"}, 71'(bus.data_sram_wdata), 71'(x[38:7]));
            if (!x[40]) chk({nm, " sram_addr"}, 71'(bus.data_sram_addr), 71'(exp_res));
        end
        @(negedge clk);
        chk({nm, " no duplicate"}, 71'(bus.EX_to_MEM_valid), 71'(0));
        chk({nm, " sram_en after leave"}, 71'(bus.data_sram_en), 71'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0,  32'd5,         32'd7,         3'b000, 32'd12,        1,  0};
        vecs[1]  = '{1,  32'd5,         32'd7,         3'b000, 32'hFFFF_FFFE, 1,  0};
        vecs[2]  = '{2,  32'hFFFF_FFFF, 32'd1,         3'b000, 32'd1,         1,  0};
        vecs[3]  = '{3,  32'hFFFF_FFFF, 32'd1,         3'b000, 32'd0,         1,  0};
        vecs[4]  = '{4,  32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1,  0};
        vecs[5]  = '{5,  32'h0000_FFFF, 32'h00FF_0000, 3'b000, 32'hFF00_0000, 1,  0};
        vecs[6]  = '{6,  32'h1234_0000, 32'h0000_5678, 3'b000, 32'h1234_5678, 1,  0};
        vecs[7]  = '{7,  32'hFFFF_0000, 32'h0F0F_0F0F, 3'b000, 32'hF0F0_0F0F, 1,  0};
        vecs[8]  = '{8,  32'd1,         32'h0000_003F, 3'b000, 32'h8000_0000, 1,  0};
        vecs[9]  = '{9,  32'h8000_0000, 32'd4,         3'b000, 32'h0800_0000, 1,  0};
        vecs[10] = '{10, 32'h8000_0000, 32'd4,         3'b000, 32'hF800_0000, 1,  0};
        vecs[11] = '{11, 32'h1234_5678, 32'hABCD_0000, 3'b000, 32'hABCD_0000, 1,  0};
        vecs[12] = '{-1, 32'hFFFF_FFF9, 32'd2,         3'b011, 32'hFFFF_FFFD, 34, 33};
        vecs[13] = '{-1, 32'hFFFF_FFF9, 32'd2,         3'b111, 32'hFFFF_FFFF, 34, 33};
        vecs[14] = '{-1, 32'd10,        32'd0,         3'b001, 32'hFFFF_FFFF, 34, 33};
        vecs[15] = '{-1, 32'd10,        32'd0,         3'b111, 32'd10,        34, 33};
        vecs[16] = '{-1, 32'h8000_0000, 32'hFFFF_FFFF, 3'b011, 32'h8000_0000, 34, 33};
        vecs[17] = '{-1, 32'h8000_0000, 32'hFFFF_FFFF, 3'b111, 32'd0,         34, 33};

        reset              = 1'b1;
        bus.ID_to_EX_valid = 1'b0;
        bus.ID_EX_reg      = '0;
        bus.MEM_allow_in   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset valid",    71'(bus.EX_to_MEM_valid), 71'(0));
        chk("reset allow_in", 71'(bus.EX_allow_in), 71'(1));
        chk("reset sram_en",  71'(bus.data_sram_en), 71'(0));
        chk("reset sram_we",  71'(bus.data_sram_we), 71'(0));
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            ins = mk(32'(32'h1000 + i * 4), vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].dv,
                     1'b0, 32'h0, 1'b1, 5'(i + 3), 1'b0);
            exec($sformatf("vec%0d", i), ins, 0, vecs[i].exp, vecs[i].lat, vecs[i].lows);
        end

        // Store held off by MEM for three cycles
        ins = mk(32'h2000, 0, 32'h800, 32'h800, 3'b000, 1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
        exec("store", ins, 3, 32'h1000, 1, 0);

        // Back-to-back divides with MEM stalled five cycles on the first
        ins_a = mk(32'h3000, -1, 32'hFFFF_FF9C, 32'd7, 3'b011, 1'b0, 32'h0, 1'b1, 5'd7, 1'b0);
        ins_b = mk(32'h3004, -1, 32'd100, 32'hFFFF_FFF9, 3'b111, 1'b0, 32'h0, 1'b1, 5'd8, 1'b0);
        bus.ID_to_EX_valid = 1'b1;
        bus.ID_EX_reg      = ins_a;
        @(posedge clk);
        @(negedge clk);
        bus.ID_EX_reg = ins_b;
        lat = 1;
        while (!bus.EX_to_MEM_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        chk("b2b first latency", 71'(lat), 71'(34));
        bus.MEM_allow_in = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("b2b hold valid",    71'(bus.EX_to_MEM_valid), 71'(1));
            chk("b2b hold allow_in", 71'(bus.EX_allow_in), 71'(0));
            chk("b2b hold bundle",   bus.EX_MEM_reg, {32'h3000, 1'b1, 5'd7, 32'hFFFF_FFF2, 1'b0});
            @(negedge clk);
        end
        bus.MEM_allow_in = 1'b1;
        #1;
        chk("b2b release allow_in", 71'(bus.EX_allow_in), 71'(1));
        chk("b2b release bundle",   bus.EX_MEM_reg, {32'h3000, 1'b1, 5'd7, 32'hFFFF_FFF2, 1'b0});
        @(posedge clk);
        @(negedge clk);
        bus.ID_to_EX_valid = 1'b0;
        lat = 1;
        while (!bus.EX_to_MEM_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        chk("b2b second latency", 71'(lat), 71'(34));
        chk("b2b second bundle",  bus.EX_MEM_reg, {32'h3004, 1'b1, 5'd8, 32'd2, 1'b0});
        @(posedge clk);
        @(negedge clk);
        chk("b2b drained", 71'(bus.EX_to_MEM_valid), 71'(0));
        if (lat >= 100) recover();

        // Reset while the divider is at count 15
        ins = mk(32'h4000, -1, 32'd1000, 32'd3, 3'b001, 1'b0, 32'h0, 1'b1, 5'd9, 1'b0);
        bus.ID_to_EX_valid = 1'b1;
        bus.ID_EX_reg      = ins;
        @(posedge clk);
        @(negedge clk);
        bus.ID_to_EX_valid = 1'b0;
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset valid",    71'(bus.EX_to_MEM_valid), 71'(0));
        chk("midreset sram_en",  71'(bus.data_sram_en), 71'(0));
        chk("midreset allow_in", 71'(bus.EX_allow_in), 71'(1));
        @(negedge clk);
        ins = mk(32'h4004, 0, 32'd1, 32'd1, 3'b000, 1'b0, 32'h0, 1'b1, 5'd4, 1'b0);
        exec("post-reset add", ins, 0, 32'd2, 1, 0);

        // Random instructions against the arithmetic model
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 3));
            s1 = $urandom;
            s2 = $urandom;
            if (kind == 3) begin
                dv = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
                case ($urandom_range(0, 4))
                    0: s2 = 32'd0;
                    1: s2 = 32'($urandom_range(1, 50));
                    2: s2 = 32'(32'd0 - 32'($urandom_range(1, 50)));
                    3: begin s1 = 32'h8000_0000; s2 = 32'hFFFF_FFFF; end
                    default: ;
                endcase
                ins = mk($urandom, -1, s1, s2, dv, 1'b0, $urandom,
                         1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
                exec($sformatf("rand%0d", n), ins, int'($urandom_range(0, 2)), model(ins), 34, 33);
            end else begin
                op = int'($urandom_range(0, 11));
                ins = mk($urandom, op, s1, s2, 3'b000, 1'($urandom_range(0, 1)), $urandom,
                         1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)));
                exec($sformatf("rand%0d", n), ins, int'($urandom_range(0, 2)), model(ins), 1, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
